// File: rtl/msg_schedule_if.sv
// Word stream from the SHA-256 message schedule to the compression rounds.
// The master side presents W[t] with its index t; the slave accepts it when
// w_valid and w_ready are both high on a rising clock edge.
interface msg_schedule_if;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic [5:0]  w_index;

   modport master (output w_valid, output w_data, output w_index, input w_ready);
   modport slave  (input w_valid, input w_data, input w_index, output w_ready);
endinterface

// File: rtl/msg_schedule.sv
// SHA-256 message schedule generator.
// Fetches W0..W15 of one 512-bit block from message memory, expands W16..W63
// through a 16-word sliding window and streams W0..W63 in order.
// Build option MSG_SCHED_BSWAP_EN: when defined, each memory word is
// byte-reversed before use (little-endian memory); otherwise it is used as-is.
module msg_schedule #(
   parameter int ADDR_W = 16,
   parameter int NUM_W  = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] msg_base_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   msg_schedule_if.master    w_if,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      HOLD = 3'd3,
      EXP  = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [5:0] LAST_IDX  = 6'(NUM_W - 1);
   localparam logic [5:0] LAST_LOAD = 6'd15;

   // Small sigma functions of the SHA-256 schedule.
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

   // Memory word to schedule word; byte order depends on the build option.
   function automatic logic [31:0] mem_word(input logic [31:0] x);
`ifdef MSG_SCHED_BSWAP_EN
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
      return x;
`endif
   endfunction

   state_t                  state_r, state_s;
   logic [ADDR_W-1:0]       base_r, base_s;
   logic [5:0]              idx_r, idx_s;
   logic [15:0][31:0]       win_r, win_s;
   logic                    w_valid_r, w_valid_s;
   logic [31:0]             w_data_r, w_data_s;
   logic [5:0]              w_index_r, w_index_s;
   logic                    rd_en_r, rd_en_s;
   logic [ADDR_W-1:0]       addr_r, addr_s;
   logic                    busy_r, busy_s;
   logic                    done_r, done_s;
   logic [31:0]             fetch_word_s;
   logic [31:0]             exp_word_s;

   // win_r[0] is W[t-16], win_r[15] is W[t-1]; exp_word_s is W[t].
   assign fetch_word_s = mem_word(mem_rdata);
   assign exp_word_s   = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];

   // Next-state and next-output computation for every registered output.
   always_comb begin
      state_s   = state_r;
      base_s    = base_r;
      idx_s     = idx_r;
      win_s     = win_r;
      w_valid_s = w_valid_r;
      w_data_s  = w_data_r;
      w_index_s = w_index_r;
      case (state_r)
         IDLE: begin
            if (enable) begin
               base_s  = msg_base_addr;
               idx_s   = 6'd0;
               state_s = RD;
            end else begin
               state_s = IDLE;
            end
         end
         RD: begin
            state_s = CAP;
         end
         CAP: begin
            w_data_s  = fetch_word_s;
            w_index_s = idx_r;
            w_valid_s = 1'b1;
            win_s     = {fetch_word_s, win_r[15:1]};
            state_s   = HOLD;
         end
         HOLD: begin
            if (w_if.w_ready) begin
               w_valid_s = 1'b0;
               idx_s     = idx_r + 6'd1;
               state_s   = (idx_r == LAST_LOAD) ? EXP : RD;
            end else begin
               state_s = HOLD;
            end
         end
         EXP: begin
            if (w_valid_r && w_if.w_ready && (w_index_r == LAST_IDX)) begin
               w_valid_s = 1'b0;
               state_s   = DONE;
            end else if (!w_valid_r || w_if.w_ready) begin
               // Accept and reload in the same cycle keeps one word per clock.
               w_data_s  = exp_word_s;
               w_index_s = idx_r;
               w_valid_s = 1'b1;
               win_s     = {exp_word_s, win_r[15:1]};
               idx_s     = idx_r + 6'd1;
               state_s   = EXP;
            end else begin
               state_s = EXP;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      // Side outputs follow the state being entered so they register aligned with it.
      rd_en_s = (state_s == RD);
      addr_s  = (state_s == RD) ? (base_s + ADDR_W'(idx_s)) : addr_r;
      busy_s  = (state_s != IDLE);
      done_s  = (state_s == DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= IDLE;
         base_r    <= '0;
         idx_r     <= 6'd0;
         win_r     <= '0;
         w_valid_r <= 1'b0;
         w_data_r  <= 32'h0000_0000;
         w_index_r <= 6'd0;
         rd_en_r   <= 1'b0;
         addr_r    <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         base_r    <= base_s;
         idx_r     <= idx_s;
         win_r     <= win_s;
         w_valid_r <= w_valid_s;
         w_data_r  <= w_data_s;
         w_index_r <= w_index_s;
         rd_en_r   <= rd_en_s;
         addr_r    <= addr_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign w_if.w_valid = w_valid_r;
   assign w_if.w_data  = w_data_r;
   assign w_if.w_index = w_index_r;
   assign mem_rd_en    = rd_en_r;
   assign mem_addr     = addr_r;
   assign busy         = busy_r;
   assign done         = done_r;

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule: a memory model, a SHA-256 schedule
// reference computed from the block contents, and randomized backpressure.
module tb_msg_schedule;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [15:0] msg_base_addr;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;

   msg_schedule_if w_if ();

   msg_schedule #(.ADDR_W(16), .NUM_W(64)) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .msg_base_addr (msg_base_addr),
      .mem_rd_en     (mem_rd_en),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .w_if          (w_if),
      .busy          (busy),
      .done          (done)
   );

   logic [31:0] mem [0:65535];
   logic [31:0] exp_w [0:63];
   logic [31:0] got_w [0:63];
   int          n_checks = 0;
   int          n_err    = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory answers one cycle after the strobe; junk otherwise.
   always @(posedge clock) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
      else           mem_rdata <= $urandom;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Word as the design should see it after the optional byte reversal.
   function automatic logic [31:0] as_word(input logic [31:0] x);
`ifdef MSG_SCHED_BSWAP_EN
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
      return x;
`endif
   endfunction

   // kind: 0 "abc" block, 1 all-zero, 2 random, 3 byte-order probe.
   task automatic fill(input logic [15:0] base, input int kind);
      logic [15:0] a;
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(i);
         case (kind)
            0:       mem[a] = as_word((i == 0) ? 32'h6162_6380 : ((i == 15) ? 32'h0000_0018 : 32'h0));
            1:       mem[a] = 32'h0000_0000;
            3:       mem[a] = (i == 0) ? 32'h8063_6261 : $urandom;
            default: mem[a] = $urandom;
         endcase
      end
   endtask

   // mode: 0 ready always, 1 random ready, 2 five-cycle stall at index 20.
   task automatic run_block(input logic [15:0] base, input int mode, input bit abort30);
      int count, fetch, cyc, last_acc, done_cnt, stall, done_cyc;
      logic [15:0] a;
      logic [31:0] s0, s1, pdata;
      logic [5:0]  pidx;
      logic        pvalid, pready;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            a = base + 16'(t);
            exp_w[t] = as_word(mem[a]);
         end else begin
            s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
         end
         got_w[t] = 32'hDEAD_BEEF;
      end
      count = 0; fetch = 0; cyc = 0; last_acc = 0; done_cnt = 0; stall = 0; done_cyc = -1;
      pvalid = 1'b0; pready = 1'b1; pdata = 32'h0; pidx = 6'd0;
      msg_base_addr = base;
      enable = 1'b1;
      w_if.w_ready = 1'b0;
      while (cyc < 3000) begin
         @(posedge clock);
         #1;
         cyc++;
         enable = 1'b0;
         if (pvalid && !pready) begin
            check("hold_valid", w_if.w_valid, 1'b1);
            check("hold_data", w_if.w_data, pdata);
            check("hold_index", w_if.w_index, pidx);
         end
         if (done_cyc >= 0) begin
            check("busy_after_done", busy, 1'b0);
            check("done_width", done, 1'b0);
            break;
         end
         if (abort30 && w_if.w_valid && (w_if.w_index == 6'd30)) begin
            reset = 1'b1;
            w_if.w_ready = 1'b0;
            @(posedge clock);
            #1;
            check("abort_outputs", {mem_rd_en, mem_addr, w_if.w_valid, w_if.w_data, w_if.w_index, busy, done}, 64'h0);
            reset = 1'b0;
            return;
         end
         if (mem_rd_en) begin
            a = base + 16'(fetch);
            check("mem_addr", mem_addr, a);
            fetch++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_latency", cyc, last_acc + 1);
            check("done_count", count, 64);
         end
         case (mode)
            0:       w_if.w_ready = 1'b1;
            1:       w_if.w_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (w_if.w_valid && (w_if.w_index == 6'd20) && (stall < 5)) begin
                  w_if.w_ready = 1'b0;
                  stall++;
               end else begin
                  w_if.w_ready = 1'b1;
               end
            end
         endcase
         if (w_if.w_valid && w_if.w_ready) begin
            if (count < 64) begin
               check("w_index", w_if.w_index, count);
               check("w_data", w_if.w_data, exp_w[count]);
               got_w[count] = w_if.w_data;
               if (mode == 0) begin
                  if (count == 0)       check("first_latency", cyc, 3);
                  else if (count < 16)  check("fetch_gap", cyc - last_acc, 3);
                  else if (count == 16) check("bubble_gap", cyc - last_acc, 2);
                  else                  check("expand_gap", cyc - last_acc, 1);
               end
            end else begin
               check("extra_word", count, 63);
            end
            count++;
            last_acc = cyc;
         end
         pvalid = w_if.w_valid;
         pready = w_if.w_ready;
         pdata  = w_if.w_data;
         pidx   = w_if.w_index;
      end
      if (done_cyc < 0) check("timeout", cyc, 0);
      check("words", count, 64);
      check("fetches", fetch, 16);
      check("done_pulses", done_cnt, 1);
      if (mode == 2) check("stall_cycles", stall, 5);
      w_if.w_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] b;
      reset = 1'b1;
      enable = 1'b0;
      msg_base_addr = 16'h0;
      w_if.w_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_outputs", {mem_rd_en, mem_addr, w_if.w_valid, w_if.w_data, w_if.w_index, busy, done}, 64'h0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("idle_busy", busy, 1'b0);

      // "abc" padded block with ready held high.
      b = 16'h1200;
      fill(b, 0);
      run_block(b, 0, 1'b0);
      check("abc_w0", got_w[0], 32'h6162_6380);
      check("abc_w15", got_w[15], 32'h0000_0018);
      check("abc_w16", got_w[16], 32'h6162_6380);
      check("abc_w17", got_w[17], 32'h000F_0000);
      check("abc_w18", got_w[18], 32'h7DA8_6405);

      // All-zero block under random backpressure.
      b = 16'($urandom);
      fill(b, 1);
      run_block(b, 1, 1'b0);
      check("zero_w63", got_w[63], 32'h0);

      // Five-cycle stall while index 20 is presented.
      b = 16'($urandom);
      fill(b, 2);
      run_block(b, 2, 1'b0);

      // Reset at index 30, then the same block again from W0.
      b = 16'($urandom);
      fill(b, 2);
      run_block(b, 1, 1'b1);
      @(posedge clock);
      #1;
      check("post_abort_busy", busy, 1'b0);
      run_block(b, 0, 1'b0);

      // Address wrap across the top of memory.
      fill(16'hFFF8, 2);
      run_block(16'hFFF8, 1, 1'b0);

      // Byte order of the first word.
      b = 16'($urandom);
      fill(b, 3);
      run_block(b, 0, 1'b0);
`ifdef MSG_SCHED_BSWAP_EN
      check("byte_order_w0", got_w[0], 32'h6162_6380);
`else
      check("byte_order_w0", got_w[0], 32'h8063_6261);
`endif

      // A few fully random blocks.
      for (int k = 0; k < 3; k++) begin
         b = 16'($urandom);
         fill(b, 2);
         run_block(b, 1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
